swap_pair_feeder: RTL and testbench

//  Upstream stage of the register-swap unit: packs an 8-bit byte stream into (a,b) operand pairs.

---
 rtl/swap_pkg.sv | 12 +
 rtl/swap_pair_feeder.sv | 120 ++++++++++++
 tb/tb_swap_pair_feeder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/swap_pkg.sv
// Shared definitions for the register-swap unit: pair-feeder state encoding and defaults.
package swap_pkg;

   localparam int DW_DEF = 8;
   localparam int CW_DEF = 16;
   localparam logic [DW_DEF-1:0] PAD_DEF = 8'd0;

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_HALF  = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b10;

endpackage

// File: rtl/swap_pair_feeder.sv
// Packs a byte stream into (a,b) operand pairs for the swap stage; flush pads a lone byte.
// Optional SWAP_PAIR_CMP_EN adds need_swap = registered (out_a > out_b).
module swap_pair_feeder
   import swap_pkg::*;
#(
   parameter int              DW      = DW_DEF,
   parameter int              CW      = CW_DEF,
   parameter logic [DW-1:0]   PAD_VAL = DW'(PAD_DEF)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          flush,
   output logic [DW-1:0] out_a,
   output logic [DW-1:0] out_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_padded,
   output logic [CW-1:0] pair_cnt,
`ifdef SWAP_PAIR_CMP_EN
   output logic          need_swap,
`endif
   output logic [1:0]    dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // in_ready in FULL follows out_ready combinationally so packing continues back to back.

   logic [1:0]    r_state;
   logic [DW-1:0] r_out_a;
   logic [DW-1:0] r_out_b;
   logic          r_padded;
   logic [CW-1:0] r_cnt;
   logic          w_full;
   logic          w_in_fire;
   logic          w_out_fire;

   assign w_full     = (r_state == ST_FULL);
   assign in_ready   = !w_full || out_ready;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = w_full && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_EMPTY;
         r_out_a  <= '0;
         r_out_b  <= '0;
         r_padded <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  r_out_a <= in_data;
                  r_state <= ST_HALF;
               end
            end
            ST_HALF: begin
               // A byte arriving with flush completes the pair normally; the flush is dropped.
               if (w_in_fire) begin
                  r_out_b  <= in_data;
                  r_padded <= 1'b0;
                  r_state  <= ST_FULL;
               end else if (flush) begin
                  r_out_b  <= PAD_VAL;
                  r_padded <= 1'b1;
                  r_state  <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  if (w_in_fire) begin
                     r_out_a <= in_data;
                     r_state <= ST_HALF;
                  end else begin
                     r_state <= ST_EMPTY;
                  end
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_out_fire) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

`ifdef SWAP_PAIR_CMP_EN
   logic r_need_swap;

   // Compared against the incoming b so the flag is ready together with out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_need_swap <= 1'b0;
      end else if (r_state == ST_HALF) begin
         if (w_in_fire) begin
            r_need_swap <= (r_out_a > in_data);
         end else if (flush) begin
            r_need_swap <= (r_out_a > PAD_VAL);
         end
      end
   end

   assign need_swap = r_need_swap;
`endif

   assign out_a      = r_out_a;
   assign out_b      = r_out_b;
   assign out_valid  = w_full;
   assign out_padded = r_padded;
   assign pair_cnt   = r_cnt;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_swap_pair_feeder.sv
// Self-checking bench for swap_pair_feeder: vector table, hand sequences and random traffic
// against a queue-based pairing model. Define SWAP_PAIR_CMP_EN to cover need_swap.
module tb_swap_pair_feeder;
   import swap_pkg::*;

   localparam logic [7:0] PAD = 8'd0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, out_padded;
   logic [7:0]  out_a, out_b;
   logic [15:0] pair_cnt;
   logic [1:0]  dbg_state;
   logic        in_ready4, out_valid4, out_padded4;
   logic [7:0]  out_a4, out_b4;
   logic [3:0]  pair_cnt4;
   logic [1:0]  dbg_state4;
`ifdef SWAP_PAIR_CMP_EN
   logic        need_swap, need_swap4;
`endif

   always #5 clk = ~clk;

   swap_pair_feeder dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_padded(out_padded), .pair_cnt(pair_cnt),
`ifdef SWAP_PAIR_CMP_EN
      .need_swap(need_swap),
`endif
      .dbg_state(dbg_state)
   );

   swap_pair_feeder #(.CW(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
      .flush(flush), .out_a(out_a4), .out_b(out_b4), .out_valid(out_valid4), .out_ready(out_ready),
      .out_padded(out_padded4), .pair_cnt(pair_cnt4),
`ifdef SWAP_PAIR_CMP_EN
      .need_swap(need_swap4),
`endif
      .dbg_state(dbg_state4)
   );

   // Scoreboard: exp_q holds at most one closed pair {a,b,pad}; pend_q holds bytes not yet paired.
   logic [16:0] exp_q[$];
   logic [7:0]  pend_q[$];
   int unsigned m_cnt;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        m_rdy;

   typedef struct {
      logic       v; logic [7:0] d; logic f; logic r;
      logic       e_rdy; logic e_valid; logic [7:0] e_a; logic [7:0] e_b; logic e_pad;
      logic [15:0] e_cnt;
   } vec_t;
   vec_t vec[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      pend_q.delete();
      m_cnt = 0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Drive one cycle of inputs and check DUT outputs against the model before the edge.
   task automatic drive_check(input logic v, input logic [7:0] d, input logic f, input logic r);
      logic [16:0] p;
      in_valid = v; in_data = d; flush = f; out_ready = r;
      @(negedge clk);
      m_rdy = (exp_q.size() == 0) || r;
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         p = exp_q[0];
         chk("out_a", out_a, p[16:9]);
         chk("out_b", out_b, p[8:1]);
         chk("out_padded", out_padded, p[0]);
`ifdef SWAP_PAIR_CMP_EN
         chk("need_swap", need_swap, p[16:9] > p[8:1]);
`endif
      end
      chk("pair_cnt", pair_cnt, m_cnt % 65536);
      chk("pair_cnt_cw4", pair_cnt4, m_cnt % 16);
   endtask

   task automatic advance();
      if (exp_q.size() != 0 && out_ready) begin
         void'(exp_q.pop_front());
         m_cnt++;
      end
      if (in_valid && m_rdy) begin
         pend_q.push_back(in_data);
         if (pend_q.size() == 2) begin
            exp_q.push_back({pend_q[0], pend_q[1], 1'b0});
            pend_q.delete();
         end
      end else if (flush && pend_q.size() == 1) begin
         exp_q.push_back({pend_q[0], PAD, 1'b1});
         pend_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
      drive_check(v, d, f, r);
      advance();
   endtask

`ifdef SWAP_PAIR_CMP_EN
   task automatic pair_ns(input logic [7:0] a, input logic [7:0] b, input logic e);
      step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, b, 1'b0, 1'b0);
      drive_check(1'b0, 8'h00, 1'b0, 1'b0);
      chk("need_swap_pair", need_swap, e);
      advance();
      step(1'b0, 8'h00, 1'b0, 1'b1);
   endtask
`endif

   initial begin
      //          v     d      f     r     rdy   valid a      b      pad   cnt
      vec[0]  = '{1'b1, 8'h0A, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 16'd0};
      vec[1]  = '{1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 16'd0};
      vec[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 8'h14, 1'b0, 16'd0};
      vec[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 8'h14, 1'b0, 16'd0};
      vec[4]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0A, 8'h14, 1'b0, 16'd0};
      vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 16'd1};
      vec[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, PAD,   1'b1, 16'd1};
      vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 16'd2};
      vec[8]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 16'd2};
      vec[9]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 16'd2};
      vec[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 8'h77, 1'b0, 16'd2};
      vec[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 8'h77, 1'b0, 16'd2};
      vec[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 16'd3};

      do_reset();
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_cnt", pair_cnt, 16'd0);
      chk("reset_a", out_a, 8'h00);
      chk("reset_padded", out_padded, 1'b0);
      chk("reset_state", dbg_state, ST_EMPTY);

      for (int i = 0; i < 13; i++) begin
         drive_check(vec[i].v, vec[i].d, vec[i].f, vec[i].r);
         chk($sformatf("vec%0d_in_ready", i), in_ready, vec[i].e_rdy);
         chk($sformatf("vec%0d_out_valid", i), out_valid, vec[i].e_valid);
         chk($sformatf("vec%0d_pair_cnt", i), pair_cnt, vec[i].e_cnt);
         if (vec[i].e_valid) begin
            chk($sformatf("vec%0d_out_a", i), out_a, vec[i].e_a);
            chk($sformatf("vec%0d_out_b", i), out_b, vec[i].e_b);
            chk($sformatf("vec%0d_padded", i), out_padded, vec[i].e_pad);
         end
         advance();
         if (i == 4) chk("backpressure_release_state", dbg_state, ST_HALF);
      end

      // Asynchronous reset while a pair is held and the counter is non-zero.
      step(1'b1, 8'h0A, 1'b0, 1'b0);
      step(1'b1, 8'h14, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      chk("pre_reset_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid", out_valid, 1'b0);
      chk("async_reset_cnt", pair_cnt, 16'd0);
      chk("async_reset_state", dbg_state, ST_EMPTY);
      do_reset();

      // 17 back-to-back pairs: the 4-bit counter wraps through zero to 1.
      for (int k = 0; k < 34; k++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("wrap_cw4", pair_cnt4, 4'd1);
      chk("wrap_cw16", pair_cnt, 16'd17);

`ifdef SWAP_PAIR_CMP_EN
      do_reset();
      pair_ns(8'h14, 8'h0A, 1'b1);
      pair_ns(8'h0A, 8'h14, 1'b0);
      pair_ns(8'h20, 8'h20, 1'b0);
`endif

      do_reset();
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 3) != 0,
              ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3)),
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
